// File: rtl/dmem_pkg.sv
// Shared types and elaboration helpers for the parametrised data memory bank.
// Word geometry is always derived from the instantiating module's parameters.
package dmem_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_ADDR_W = 32;

  // Ceiling log2; returns 0 for value <= 1, so a one-byte word has no offset bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit width_ok(input int data_w);
    return (data_w > 0) && (data_w % 8 == 0);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((1 << clog2(depth)) == depth);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a datapath master and the data memory bank.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  // Handshake: a request (we/be/addr/wdata) is accepted on a rising clk edge
  // where req_valid and req_ready are both 1; the master holds the request
  // fields stable while req_valid=1 and req_ready=0. Every accepted request
  // yields exactly one resp_valid pulse in the following cycle; err qualifies
  // that pulse, and rdata carries read data during a read response.
  logic                  req_valid;
  logic                  req_ready;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  resp_valid;
  logic                  err;

  modport master (
    output req_valid, we, be, addr, wdata,
    input  req_ready, rdata, resp_valid, err
  );

  modport slave (
    input  req_valid, we, be, addr, wdata,
    output req_ready, rdata, resp_valid, err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH x DATA_W RAM with byte-lane write enables and a registered
// read port. No reset on the storage so it maps onto block RAM.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int BYTES  = bytes_of(DATA_W),
  localparam int IDX_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wen,
  input  logic              ren,
  input  logic [BYTES-1:0]  be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (ren) q <= mem[idx];
  end

endmodule

// File: rtl/data_mem_bank.sv
// Parametrised data memory: init walker FSM, byte-address decode with range and
// alignment checks, and a one-cycle registered response path around dmem_array.
module data_mem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  dmem_if.slave  bus,
  output logic   init_busy,
  output state_t dbg_state
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int OFF_W = clog2(BYTES);
  localparam int IDX_W = clog2(DEPTH);
  localparam int SHIFT = OFF_W + IDX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  if (!width_ok(DATA_W) || !depth_ok(DEPTH) || SHIFT > ADDR_W) begin : g_bad_param
    $error("data_mem_bank: illegal DATA_W/DEPTH/ADDR_W combination");
  end

  state_t             state;
  logic [IDX_W-1:0]   init_cnt;
  logic               resp_valid_q;
  logic               err_q;
  logic               rd_pending;
  logic [DATA_W-1:0]  rdata_q;

  logic               accept;
  logic               misaligned;
  logic               out_of_range;
  logic               rejected;
  logic [IDX_W-1:0]   req_idx;

  logic               arr_wen;
  logic               arr_ren;
  logic [BYTES-1:0]   arr_be;
  logic [IDX_W-1:0]   arr_idx;
  logic [DATA_W-1:0]  arr_wdata;
  logic [DATA_W-1:0]  arr_q;

  assign bus.req_ready = (state == IDLE) && !clr;
  assign accept        = bus.req_valid && bus.req_ready;
  assign misaligned    = (bus.addr & OFF_MASK) != '0;
  assign out_of_range  = (bus.addr >> SHIFT) != '0;
  assign rejected      = misaligned || out_of_range;
  assign req_idx       = bus.addr[OFF_W +: IDX_W];

  // The walker owns the single RAM port while INIT; requests are never ready then.
  always_comb begin
    arr_wen   = 1'b0;
    arr_ren   = 1'b0;
    arr_be    = '0;
    arr_idx   = req_idx;
    arr_wdata = bus.wdata;
    if (state == INIT) begin
      arr_wen   = 1'b1;
      arr_be    = '1;
      arr_idx   = init_cnt;
      arr_wdata = '0;
    end else if (accept && !rejected) begin
      if (bus.we) begin
        arr_wen = 1'b1;
        arr_be  = bus.be;
      end else begin
        arr_ren = 1'b1;
      end
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .wen   (arr_wen),
    .ren   (arr_ren),
    .be    (arr_be),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .q     (arr_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= INIT;
      init_cnt     <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rd_pending   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= accept;
      err_q        <= accept && rejected;
      rd_pending   <= accept && !bus.we && !rejected;

      // rdata_q tracks the visible read value so it persists past the response.
      if (rd_pending) rdata_q <= arr_q;
      if (accept && rejected) rdata_q <= '0;

      case (state)
        INIT: begin
          if (clr) begin
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + IDX_W'(1);
            if (init_cnt == IDX_W'(DEPTH - 1)) state <= IDLE;
          end
        end
        IDLE: begin
          if (clr) begin
            state    <= INIT;
            init_cnt <= '0;
          end
        end
        default: begin
          state    <= INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

  // During a read response the RAM output register is shown directly.
  assign bus.rdata      = rd_pending ? arr_q : rdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.err        = err_q;
  assign init_busy      = (state == INIT);
  assign dbg_state      = state;

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench for data_mem_bank: driver tasks push expected responses into a
// queue that an independent negedge monitor pops and compares.
module tb_data_mem_bank;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_n;
  logic   clr, clr2;
  logic   init_busy, init_busy2;
  state_t st, st2;

  dmem_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  dmem_if #(.DATA_W(64), .ADDR_W(32)) bus2 ();

  data_mem_bank #(.DATA_W(32), .DEPTH(256), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .clr       (clr),
    .bus       (bus),
    .init_busy (init_busy),
    .dbg_state (st)
  );

  data_mem_bank #(.DATA_W(64), .DEPTH(16), .ADDR_W(32)) dut2 (
    .clk       (clk),
    .rst       (rst_n),
    .clr       (clr2),
    .bus       (bus2),
    .init_busy (init_busy2),
    .dbg_state (st2)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [32:0] mon_e;
  logic [31:0] model_rd = '0;
  int          run_len  = 0;
  int          max_run  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding");
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err", 64'(bus.err), 64'(mon_e[32]));
        check("resp_rdata", 64'(bus.rdata), 64'(mon_e[31:0]));
      end
    end else begin
      run_len = 0;
      if (rst_n === 1'b1) check("err_idle", 64'(bus.err), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err,
                       input logic [31:0] exp_rd, output logic acc);
    bus.req_valid = 1'b1;
    bus.we        = w;
    bus.be        = b;
    bus.addr      = a;
    bus.wdata     = d;
    #1;
    acc = bus.req_ready;
    @(posedge clk);
    if (acc) begin
      if (exp_err)  model_rd = '0;
      else if (!w)  model_rd = exp_rd;
      exp_q.push_back({exp_err, model_rd});
    end
    #1;
  endtask

  task automatic req(input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
    logic acc;
    issue(w, b, a, d, exp_err, exp_rd, acc);
    check("req_accepted", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts edges until init_busy falls; req_ready must stay low meanwhile.
  task automatic wait_init(input string name);
    int n;
    int ready_seen;
    n = 0;
    ready_seen = 0;
    do begin
      if (init_busy && bus.req_ready) ready_seen++;
      @(posedge clk);
      #1;
      n++;
    end while (init_busy && n < 1000);
    check(name, 64'(n), 64'd256);
    check({name, "_ready_low"}, 64'(ready_seen), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    bus.req_valid  = 1'b0; bus.we  = 1'b0; bus.be  = '0; bus.addr  = '0; bus.wdata  = '0;
    bus2.req_valid = 1'b0; bus2.we = 1'b0; bus2.be = '0; bus2.addr = '0; bus2.wdata = '0;
    clr  = 1'b0;
    clr2 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_init_busy", 64'(init_busy), 64'd1);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_state", 64'(st), 64'(INIT));

    // 1: init length and cleared contents
    @(negedge clk) rst_n = 1'b1;
    wait_init("init_len_reset");
    req(1'b0, 4'h0, 32'h000, 32'h0, 1'b0, 32'h0000_0000);
    req(1'b0, 4'h0, 32'h004, 32'h0, 1'b0, 32'h0000_0000);
    req(1'b0, 4'h0, 32'h3FC, 32'h0, 1'b0, 32'h0000_0000);

    // 2: full and partial byte writes
    req(1'b1, 4'hF, 32'h010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    req(1'b0, 4'h0, 32'h010, 32'h0,         1'b0, 32'hDEAD_BEEF);
    req(1'b1, 4'h5, 32'h010, 32'h1122_3344, 1'b0, 32'h0);
    req(1'b0, 4'h0, 32'h010, 32'h0,         1'b0, 32'hDE22_BE44);

    // 3: misaligned read, out-of-range write (aliases word 0 if decoded wrongly)
    req(1'b0, 4'h0, 32'h012, 32'h0,         1'b1, 32'h0);
    req(1'b1, 4'hF, 32'h400, 32'hCAFE_F00D, 1'b1, 32'h0);
    req(1'b0, 4'h0, 32'h000, 32'h0,         1'b0, 32'h0000_0000);
    req(1'b0, 4'h0, 32'h010, 32'h0,         1'b0, 32'hDE22_BE44);
    req(1'b1, 4'h0, 32'h010, 32'hFFFF_FFFF, 1'b0, 32'h0);
    req(1'b0, 4'h0, 32'h010, 32'h0,         1'b0, 32'hDE22_BE44);

    // 4: sixteen back-to-back requests
    idle(2);
    max_run = 0;
    for (int i = 0; i < 8; i++) req(1'b1, 4'hF, 32'h20 + 32'(4 * i), 32'(i), 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) req(1'b0, 4'h0, 32'h20 + 32'(4 * i), 32'h0, 1'b0, 32'(i));
    idle(3);
    check("b2b_run", 64'(max_run), 64'd16);

    // 5: clr blocks a concurrent request and re-zeroes the array
    req(1'b1, 4'hF, 32'h008, 32'h55AA_55AA, 1'b0, 32'h0);
    req(1'b0, 4'h0, 32'h008, 32'h0,         1'b0, 32'h55AA_55AA);
    clr = 1'b1;
    issue(1'b1, 4'hF, 32'h008, 32'hFFFF_FFFF, 1'b0, 32'h0, acc);
    check("clr_blocks_req", 64'(acc), 64'd0);
    clr = 1'b0;
    bus.req_valid = 1'b0;
    wait_init("init_len_clr");
    req(1'b0, 4'h0, 32'h008, 32'h0, 1'b0, 32'h0000_0000);

    // 6: reset in the middle of the walk
    req(1'b1, 4'hF, 32'h010, 32'hA5A5_A5A5, 1'b0, 32'h0);
    req(1'b0, 4'h0, 32'h010, 32'h0,         1'b0, 32'hA5A5_A5A5);
    idle(1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("rdata_hold_init", 64'(bus.rdata), 64'hA5A5_A5A5);
    check("busy_after_clr", 64'(init_busy), 64'd1);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", 64'(bus.rdata), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("midrst_init_busy", 64'(init_busy), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_init("init_len_midrst");
    req(1'b0, 4'h0, 32'h010, 32'h0, 1'b0, 32'h0000_0000);
    idle(2);

    // 6b: 64-bit, 16-word instance, top byte lane only
    check("w64_ready", 64'(bus2.req_ready), 64'd1);
    bus2.req_valid = 1'b1;
    bus2.we        = 1'b1;
    bus2.be        = 8'h80;
    bus2.addr      = 32'h78;
    bus2.wdata     = 64'hAB12_3456_789A_BCDE;
    @(posedge clk);
    #1;
    check("w64_wr_resp", 64'(bus2.resp_valid), 64'd1);
    bus2.we = 1'b0;
    bus2.be = 8'h00;
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;
    check("w64_rd_resp", 64'(bus2.resp_valid), 64'd1);
    check("w64_rd_err", 64'(bus2.err), 64'd0);
    check("w64_rd_data", bus2.rdata, 64'hAB00_0000_0000_0000);

    idle(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
